// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// opcode values, IR field positions and the opcode-to-group classifier.
package cpu_ctrl_pkg;

    localparam int OP_W        = 5;
    localparam int REG_FIELD_W = 4;

    localparam int OP_LSB = 27;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // Instructions sharing an execute sequence; undefined opcodes behave as NOP.
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_HALT,
        CLS_NOP
    } op_class_t;

    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: classify = CLS_ALU;
            OP_NEG, OP_NOT:                 classify = CLS_UNARY;
            OP_MUL, OP_DIV:                 classify = CLS_MULDIV;
            OP_HALT:                        classify = CLS_HALT;
            default:                        classify = CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// One-hot register select: drives exactly one enable for the chosen register
// when en is high, otherwise all zero.
module reg_select_decoder #(
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) and execute (T3-T6) strobes
// decoded from the state register and the datapath IR.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                mem_rdy,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCout,
    output logic                PCin,
    output logic                incPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                read,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                ZLowOut,
    output logic                ZHighOut,
    output logic                HIin,
    output logic                LOin,
    output logic [OPW-1:0]      opcode,
    output logic                halted
);

    state_t                 state_q, state_d;
    op_class_t              op_class;
    logic [OPW-1:0]         op;
    logic [REG_FIELD_W-1:0] ra, rb, rc;
    logic [REG_FIELD_W-1:0] rin_sel, rout_sel;
    logic                   rin_en, rout_en;
    state_t                 end_state;
    logic                   ir_unused;

    assign op        = ir[OP_LSB +: OPW];
    assign ra        = ir[RA_LSB +: REG_FIELD_W];
    assign rb        = ir[RB_LSB +: REG_FIELD_W];
    assign rc        = ir[RC_LSB +: REG_FIELD_W];
    assign ir_unused = ^ir[RC_LSB-1:0];
    assign op_class  = classify(op);
    // run is only consulted here and in IDLE, so a running instruction always completes.
    assign end_state = run ? S_T0 : S_IDLE;

    // NOTE: only the state register is reset; every output is decoded from it,
    // so asserting clear zeroes all strobes without waiting for a clock edge.
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        rin_en   = 1'b0;
        rin_sel  = '0;
        rout_en  = 1'b0;
        rout_sel = '0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        incPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        read     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        opcode   = '0;
        halted   = 1'b0;

        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                incPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            // Held while memory is busy; re-loading PC+1 each cycle is harmless.
            S_T1: begin
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_rdy) state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                case (op_class)
                    CLS_ALU: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                        Yin      = 1'b1;
                        state_d  = S_T4;
                    end
                    CLS_UNARY: begin
                        rout_en  = 1'b1;
                        rout_sel = rb;
                        Zin      = 1'b1;
                        opcode   = op;
                        state_d  = S_T4;
                    end
                    CLS_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        Yin      = 1'b1;
                        state_d  = S_T4;
                    end
                    CLS_HALT: state_d = S_HALT;
                    default:  state_d = end_state;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CLS_ALU, CLS_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = (op_class == CLS_ALU) ? rc : rb;
                        Zin      = 1'b1;
                        opcode   = op;
                        state_d  = S_T5;
                    end
                    CLS_UNARY: begin
                        ZLowOut = 1'b1;
                        rin_en  = 1'b1;
                        rin_sel = ra;
                        state_d = end_state;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_T5: begin
                case (op_class)
                    CLS_ALU: begin
                        ZLowOut = 1'b1;
                        rin_en  = 1'b1;
                        rin_sel = ra;
                        state_d = end_state;
                    end
                    CLS_MULDIV: begin
                        ZLowOut = 1'b1;
                        LOin    = 1'b1;
                        state_d = S_T6;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_T6: begin
                ZHighOut = 1'b1;
                HIin     = 1'b1;
                state_d  = end_state;
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (Rin)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random
// instructions, compared cycle by cycle against a micro-step list model.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, run, mem_rdy;
    logic [31:0] ir;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin;
    logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
    logic [4:0]  opcode;
    logic        halted;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    control_sequencer #(.NUM_REGS(16), .OPW(5)) dut (
        .clock    (clock),
        .clear    (clear),
        .run      (run),
        .ir       (ir),
        .mem_rdy  (mem_rdy),
        .Rin      (Rin),
        .Rout     (Rout),
        .PCout    (PCout),
        .PCin     (PCin),
        .incPC    (incPC),
        .MARin    (MARin),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .read     (read),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .ZLowOut  (ZLowOut),
        .ZHighOut (ZHighOut),
        .HIin     (HIin),
        .LOin     (LOin),
        .opcode   (opcode),
        .halted   (halted)
    );

    // Snapshot of every output in one comparable vector.
    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [13:0] strb;
        logic [4:0]  opc;
        logic        hlt;
    } obs_t;

    localparam logic [13:0] M_PCOUT = 14'h2000, M_PCIN  = 14'h1000, M_INCPC = 14'h0800;
    localparam logic [13:0] M_MARIN = 14'h0400, M_MDRIN = 14'h0200, M_MDROUT = 14'h0100;
    localparam logic [13:0] M_READ  = 14'h0080, M_IRIN  = 14'h0040, M_YIN   = 14'h0020;
    localparam logic [13:0] M_ZIN   = 14'h0010, M_ZLO   = 14'h0008, M_ZHI   = 14'h0004;
    localparam logic [13:0] M_HIIN  = 14'h0002, M_LOIN  = 14'h0001;

    localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110;
    localparam logic [4:0] SHR = 5'b00111, SHL = 5'b01000, ROR = 5'b01001, ROL = 5'b01010;
    localparam logic [4:0] MUL = 5'b01111, DIV = 5'b10000, NEG = 5'b10001, NOT_ = 5'b10010;
    localparam logic [4:0] NOP = 5'b11010, HLT = 5'b11011;

    logic [4:0] op_tab [13] = '{ADD, SUB, AND_, OR_, SHR, SHL, ROR, ROL, MUL, DIV, NEG, NOT_, NOP};

    obs_t exp_q[$];
    obs_t zero_obs = '0;

    function automatic obs_t observe();
        return {Rin, Rout, PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin,
                Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, opcode, halted};
    endfunction

    function automatic obs_t mk(input logic [13:0] s, input logic [15:0] ri,
                                input logic [15:0] ro, input logic [4:0] oc, input logic h);
        obs_t o;
        o.strb = s; o.rin = ri; o.rout = ro; o.opc = oc; o.hlt = h;
        return o;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] r);
        return 16'h0001 << r;
    endfunction

    // Expected output list for one instruction, one entry per clock cycle.
    function automatic void build(input logic [31:0] instr, input int stall);
        logic [4:0]  op;
        logic [15:0] ra, rb, rc;
        op = instr[31:27];
        ra = oh(instr[26:23]);
        rb = oh(instr[22:19]);
        rc = oh(instr[18:15]);
        exp_q.delete();
        exp_q.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0, 0, 0, 0));
        for (int k = 0; k <= stall; k++)
            exp_q.push_back(mk(M_ZLO | M_PCIN | M_READ | M_MDRIN, 0, 0, 0, 0));
        exp_q.push_back(mk(M_MDROUT | M_IRIN, 0, 0, 0, 0));
        if (op inside {ADD, SUB, AND_, OR_, SHR, SHL, ROR, ROL}) begin
            exp_q.push_back(mk(M_YIN, 0, rb, 0, 0));
            exp_q.push_back(mk(M_ZIN, 0, rc, op, 0));
            exp_q.push_back(mk(M_ZLO, ra, 0, 0, 0));
        end else if (op inside {NEG, NOT_}) begin
            exp_q.push_back(mk(M_ZIN, 0, rb, op, 0));
            exp_q.push_back(mk(M_ZLO, ra, 0, 0, 0));
        end else if (op inside {MUL, DIV}) begin
            exp_q.push_back(mk(M_YIN, 0, ra, 0, 0));
            exp_q.push_back(mk(M_ZIN, 0, rb, op, 0));
            exp_q.push_back(mk(M_ZLO | M_LOIN, 0, 0, 0, 0));
            exp_q.push_back(mk(M_ZHI | M_HIIN, 0, 0, 0, 0));
        end else begin
            exp_q.push_back(zero_obs);
        end
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic check_true(input string tag, input logic cond);
        checks++;
        assert (cond === 1'b1) else begin
            errors++;
            $error("FAIL %s: got=%b want=1", tag, cond);
        end
    endtask

    // One cycle in IDLE (or any strobe-free state) with the given run level.
    task automatic idle_cycle(input logic run_val, input string tag);
        run = run_val; mem_rdy = 1'($urandom); ir = $urandom;
        #1 check(tag, observe(), zero_obs);
        @(posedge clock); #1;
    endtask

    // Steps through one instruction starting in T0; abort_at >= 0 asserts clear
    // mid-cycle after that step has been checked.
    task automatic run_instr(input logic [31:0] instr, input int stall,
                             input logic run_after, input int abort_at);
        build(instr, stall);
        for (int i = 0; i < exp_q.size(); i++) begin
            ir      = (i >= stall + 3) ? instr : $urandom;
            mem_rdy = (i >= 1 && i <= stall + 1) ? ((i - 1) == stall) : 1'($urandom);
            run     = (i == exp_q.size() - 1) ? run_after : 1'($urandom);
            #1;
            check($sformatf("op%02h stall%0d step%0d", instr[31:27], stall, i), observe(), exp_q[i]);
            check_true("rout_onehot", $countones(Rout) <= 1);
            check_true("hi_lo_exclusive", !(HIin && LOin));
            if (i == abort_at) begin
                clear = 1'b1;
                #1 check("clear_async", observe(), zero_obs);
                return;
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        clear = 1'b1; run = 1'b0; mem_rdy = 1'b0; ir = '0;
        @(posedge clock); #1;
        check("reset", observe(), zero_obs);
        @(posedge clock); #1;
        clear = 1'b0;
        idle_cycle(1'b0, "idle_run0_a");
        idle_cycle(1'b0, "idle_run0_b");
        idle_cycle(1'b1, "idle_start");

        run_instr(32'h1A1B8000, 0, 1'b1, -1);  // ADD R4,R3,R7
        run_instr(32'h8A800000, 0, 1'b1, -1);  // NEG R5,R0
        run_instr(32'h1A1B8000, 3, 1'b1, -1);  // ADD with 3-cycle memory wait
        run_instr(32'h79300000, 0, 1'b1, -1);  // MUL R2,R6
        run_instr(32'hD0000000, 0, 1'b1, -1);  // NOP
        run_instr(32'hF8000000, 1, 1'b1, -1);  // undefined opcode

        // clear during T4 of an ADD, then stay idle with run low
        run_instr(32'h1A1B8000, 0, 1'b1, 4);
        run = 1'b0;
        @(posedge clock); #1;
        check("clear_held", observe(), zero_obs);
        clear = 1'b0;
        for (int n = 0; n < 3; n++) idle_cycle(1'b0, "post_clear_idle");
        idle_cycle(1'b1, "restart");

        for (int n = 0; n < 150; n++) begin
            logic [31:0] instr;
            int          stall;
            logic        cont;
            instr = $urandom;
            if ($urandom_range(0, 1) == 1) instr[31:27] = op_tab[$urandom_range(0, 12)];
            if (instr[31:27] == HLT) instr[31:27] = NOP;
            stall = $urandom_range(0, 3);
            cont  = 1'($urandom);
            run_instr(instr, stall, cont, -1);
            if (!cont) begin
                idle_cycle(1'b0, "rand_idle");
                idle_cycle(1'b1, "rand_restart");
            end
        end

        run_instr(32'hD8000000, 0, 1'b1, -1);  // HALT
        for (int n = 0; n < 10; n++) begin
            run = 1'b1; mem_rdy = 1'($urandom); ir = $urandom;
            #1 check("halted_hold", observe(), mk(0, 0, 0, 0, 1'b1));
            @(posedge clock); #1;
        end
        clear = 1'b1; run = 1'b0;
        #1 check("halt_clear", observe(), zero_obs);
        @(posedge clock); #1;
        clear = 1'b0;
        idle_cycle(1'b0, "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
